// File: rtl/stdout_uart_tx_pkg.sv
// Shared constants for the stdout console peripheral:
// bus addresses, status word layout, serializer states.
package stdout_uart_tx_pkg;

    localparam logic [23:0] STDOUT_TX_ADDR   = 24'hFFFFFE;
    localparam logic [23:0] STDOUT_STAT_ADDR = 24'hFFFFFD;
    localparam logic [23:0] STDOUT_TERM_ADDR = 24'hFFFFFF;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/stdout_uart_tx_sync_fifo.sv
// Synchronous FIFO with clock enable and occupancy count.
// A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     clk_en,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clk_en) begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (rstb && clk_en && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/stdout_uart_tx.sv
// Memory-mapped console output: bus writes feed a TX FIFO
// drained by an 8N1 serializer; status/terminate for firmware.
module stdout_uart_tx
    import stdout_uart_tx_pkg::*;
#(
    parameter int          DEPTH        = 16,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [23:0] TX_ADDR      = STDOUT_TX_ADDR,
    parameter logic [23:0] STAT_ADDR    = STDOUT_STAT_ADDR,
    parameter logic [23:0] TERM_ADDR    = STDOUT_TERM_ADDR
) (
    input  logic        i_clk,
    input  logic        i_rstb,
    input  logic        i_clk_en,
    input  logic [23:0] i_addr,
    input  logic        i_wr,
    input  logic        i_rd,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_sel,
    output logic        o_txd,
    output logic        o_busy,
    output logic        o_term
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          hit_tx;
    logic          hit_stat;
    logic          hit_term;
    logic          push_req;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          ovf;
    logic          term;
    logic [31:0]   stat;
    logic          unused_wdata;

    tx_state_e     state;
    tx_state_e     state_d;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_d;
    logic [7:0]    shift;
    logic [7:0]    shift_d;
    logic          baud_last;

    assign hit_tx       = (i_addr == TX_ADDR);
    assign hit_stat     = (i_addr == STAT_ADDR);
    assign hit_term     = (i_addr == TERM_ADDR);
    assign o_sel        = hit_tx | hit_stat | hit_term;
    assign push_req     = i_wr & hit_tx;
    assign unused_wdata = ^i_wdata[31:8];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (i_clk),
        .rstb   (i_rstb),
        .clk_en (i_clk_en),
        .push   (push_req),
        .pop    (pop),
        .wdata  (i_wdata[7:0]),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Sticky overflow (set beats clear) and terminate flag.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            ovf  <= 1'b0;
            term <= 1'b0;
        end else if (i_clk_en) begin
            if (push_req && fifo_full && !pop) begin
                ovf <= 1'b1;
            end else if (i_rd && hit_stat) begin
                ovf <= 1'b0;
            end
            if (i_wr && hit_term) term <= 1'b1;
        end
    end

    assign o_term = term;

    // Serializer state and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else if (i_clk_en) begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shift    <= shift_d;
        end
    end

    assign baud_last = (baud_cnt == BAUD_LAST);

    // Next-state logic; a new byte is fetched from IDLE or at
    // the end of STOP so consecutive frames have no idle gap.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shift_d = shift;
        pop     = 1'b0;
        unique case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    state_d = TX_START;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            TX_START: begin
                if (baud_last) begin
                    state_d = TX_DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            TX_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            TX_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = TX_START;
                        bit_d   = '0;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Line level decoded from the serializer state.
    always_comb begin
        o_txd = 1'b1;
        unique case (state)
            TX_START: o_txd = 1'b0;
            TX_DATA:  o_txd = shift[0];
            default:  o_txd = 1'b1;
        endcase
    end

    assign o_busy = ~fifo_empty | (state != TX_IDLE);

    // Status word, visible only at the status address.
    always_comb begin
        stat                           = '0;
        stat[STAT_EMPTY]               = fifo_empty;
        stat[STAT_FULL]                = fifo_full;
        stat[STAT_BUSY]                = o_busy;
        stat[STAT_OVF]                 = ovf;
        stat[STAT_CNT_LSB +: 8]        = 8'(fifo_count);
        o_rdata = hit_stat ? stat : 32'h0;
    end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Bench for stdout_uart_tx: directed scenarios plus random
// bursts, line decoded against an expected-byte queue.
module tb_stdout_uart_tx;

    localparam int D = 4;
    localparam int C = 4;
    localparam logic [23:0] A_TX = 24'hFFFFFE;
    localparam logic [23:0] A_ST = 24'hFFFFFD;
    localparam logic [23:0] A_TM = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rstb;
    logic        en;
    logic        wr;
    logic        rd;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        txd;
    logic        busy;
    logic        term;

    int checks   = 0;
    int failures = 0;

    logic line[$];
    logic busyq[$];
    int   rawq[$];
    int   rawn    = 0;
    int   holdbad = 0;
    bit   prev_en = 1'b1;
    logic prev_txd;

    stdout_uart_tx #(
        .DEPTH        (D),
        .CLKS_PER_BIT (C)
    ) dut (
        .i_clk    (clk),
        .i_rstb   (rstb),
        .i_clk_en (en),
        .i_addr   (addr),
        .i_wr     (wr),
        .i_rd     (rd),
        .i_wdata  (wdata),
        .o_rdata  (rdata),
        .o_sel    (sel),
        .o_txd    (txd),
        .o_busy   (busy),
        .o_term   (term)
    );

    always #5 clk = ~clk;

    // Line monitor: one sample per enabled cycle, plus a check
    // that the line never moves across a disabled cycle.
    always @(negedge clk) begin
        if (!prev_en && txd !== prev_txd) holdbad++;
        if (en) begin
            line.push_back(txd);
            busyq.push_back(busy);
            rawq.push_back(rawn);
        end
        rawn++;
        prev_en  = en;
        prev_txd = txd;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr_bus(input logic [23:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        cyc();
        wr    = 1'b0;
        addr  = '0;
    endtask

    function automatic logic [31:0] stat_word(input int cnt, input bit bz,
                                              input bit ov);
        logic [31:0] w;
        w        = '0;
        w[0]     = (cnt == 0);
        w[1]     = (cnt == D);
        w[2]     = bz;
        w[3]     = ov;
        w[15:8]  = 8'(cnt);
        return w;
    endfunction

    task automatic check_stat(input string tag, input logic [31:0] exp);
        addr = A_ST;
        sample();
        check(tag, rdata, exp);
        cyc();
        addr = '0;
    endtask

    function automatic int first0(input int from);
        for (int i = from; i < line.size(); i++) begin
            if (line[i] === 1'b0) return i;
        end
        return line.size();
    endfunction

    task automatic wait_idle(input string tag, input int bound, input bit rnd);
        int n;
        n = 0;
        while (busy && n < bound) begin
            en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            n++;
        end
        en = 1'b1;
        check(tag, 32'(n >= bound), 32'd0);
    endtask

    task automatic decode(input string tag, input int from,
                          input logic [7:0] exp[$], input bit no_gap);
        int         i;
        int         bad;
        int         zeros;
        logic [7:0] got;
        logic       lvl;
        i = from;
        while (i < line.size() && line[i] !== 1'b0) i++;
        for (int f = 0; f < exp.size(); f++) begin
            if (i + 10 * C > line.size()) begin
                check({tag, "_short"}, 32'(line.size()), 32'(i + 10 * C));
                return;
            end
            bad = 0;
            got = '0;
            for (int k = 0; k < 10; k++) begin
                if (k == 0)      lvl = 1'b0;
                else if (k == 9) lvl = 1'b1;
                else             lvl = exp[f][k-1];
                for (int s = 0; s < C; s++) begin
                    if (line[i + k * C + s] !== lvl) bad++;
                end
                if (k >= 1 && k <= 8) got[k-1] = line[i + k * C + C / 2];
            end
            check({tag, "_byte"}, 32'(got), 32'(exp[f]));
            check({tag, "_shape"}, 32'(bad), 32'd0);
            i += 10 * C;
            if (no_gap && f + 1 < exp.size() && i < line.size()) begin
                check({tag, "_gap"}, 32'(line[i]), 32'd0);
            end
            while (i < line.size() && line[i] !== 1'b0) i++;
        end
        zeros = 0;
        for (int j = i; j < line.size(); j++) begin
            if (line[j] === 1'b0) zeros++;
        end
        check({tag, "_tail"}, 32'(zeros), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        int         b;
        int         f;
        int         hb;
        int         n;
        int         acc;
        int         cnt;
        int         zeros;
        logic [7:0] v;

        rstb  = 1'b0;
        en    = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        addr  = '0;
        wdata = '0;
        run(3);
        rstb = 1'b1;
        en   = 1'b1;

        addr = A_ST;
        sample();
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_term", 32'(term), 32'd0);
        check("rst_sel", 32'(sel), 32'd1);
        check("rst_stat", rdata, 32'h00000001);
        cyc();
        addr = '0;

        b = line.size();
        wr_bus(A_TX, 32'h00000041);
        run(50);
        f = first0(b);
        check("t2_lat", 32'(f - b), 32'd2);
        q.delete();
        q.push_back(8'h41);
        decode("t2", b, q, 1'b1);
        check("t2_busy_stop", 32'(busyq[f + 39]), 32'd1);
        check("t2_busy_fall", 32'(busyq[f + 40]), 32'd0);
        check_stat("t2_stat", stat_word(0, 1'b0, 1'b0));

        b = line.size();
        q.delete();
        for (int k = 0; k < 6; k++) begin
            wr_bus(A_TX, 32'(8'h10 + k));
            if (k < 5) q.push_back(8'(8'h10 + k));
        end
        addr = A_ST;
        rd   = 1'b1;
        sample();
        check("t3_stat_ovf", rdata, stat_word(4, 1'b1, 1'b1));
        cyc();
        rd = 1'b0;
        sample();
        check("t3_stat_clr", rdata, stat_word(4, 1'b1, 1'b0));
        cyc();
        addr = '0;
        wait_idle("t3_idle", 2000, 1'b0);
        run(5);
        decode("t3", b, q, 1'b1);
        check_stat("t3_stat_end", stat_word(0, 1'b0, 1'b0));

        b  = line.size();
        hb = holdbad;
        wr_bus(A_TX, 32'h0000005A);
        for (int j = 0; j < 140; j++) begin
            en = 1'(j % 2);
            if (!en) begin
                wr    = 1'b1;
                addr  = A_TX;
                wdata = 32'h00000077;
            end else begin
                wr   = 1'b0;
                addr = '0;
            end
            cyc();
        end
        wr   = 1'b0;
        addr = '0;
        en   = 1'b1;
        run(5);
        q.delete();
        q.push_back(8'h5A);
        decode("t4", b, q, 1'b1);
        f = first0(b);
        check("t4_span", 32'(rawq[f + 40] - rawq[f]), 32'd80);
        check("t4_hold", 32'(holdbad - hb), 32'd0);
        check_stat("t4_stat", stat_word(0, 1'b0, 1'b0));

        wr_bus(A_TX, 32'h00000008);
        wr_bus(A_TX, 32'h00000044);
        run(18);
        check("t5_busy_pre", 32'(busy), 32'd1);
        check("t5_bit3", 32'(txd), 32'd1);
        rstb = 1'b0;
        cyc();
        rstb = 1'b1;
        b    = line.size();
        addr = A_ST;
        sample();
        check("t5_txd", 32'(txd), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_stat", rdata, 32'h00000001);
        cyc();
        addr = '0;
        run(60);
        zeros = 0;
        for (int j = b; j < line.size(); j++) begin
            if (line[j] === 1'b0) zeros++;
        end
        check("t5_quiet", 32'(zeros), 32'd0);

        addr  = A_TM;
        wdata = 32'hDEADBEEF;
        wr    = 1'b1;
        sample();
        check("t6_sel_term", 32'(sel), 32'd1);
        cyc();
        wr   = 1'b0;
        addr = A_TX;
        sample();
        check("t6_sel_tx", 32'(sel), 32'd1);
        check("t6_term", 32'(term), 32'd1);
        check("t6_rdata_tx", rdata, 32'd0);
        cyc();
        addr = '0;
        run(5);
        check("t6_term_hold", 32'(term), 32'd1);
        addr  = 24'hFFFFFC;
        wdata = 32'h00000055;
        wr    = 1'b1;
        sample();
        check("t6_sel_other", 32'(sel), 32'd0);
        check("t6_rdata_other", rdata, 32'd0);
        cyc();
        wr   = 1'b0;
        addr = '0;
        run(3);
        check("t6_busy", 32'(busy), 32'd0);
        check_stat("t6_stat", 32'h00000001);

        for (int it = 0; it < 4; it++) begin
            n   = $urandom_range(1, D + 3);
            acc = (n < D + 1) ? n : D + 1;
            cnt = (n == 1) ? 1 : acc - 1;
            b   = line.size();
            hb  = holdbad;
            q.delete();
            for (int k = 0; k < n; k++) begin
                v = 8'($urandom_range(0, 255));
                if (k < acc) q.push_back(v);
                wr_bus(A_TX, {24'($urandom), v});
            end
            addr = A_ST;
            rd   = 1'b1;
            sample();
            check("rnd_stat", rdata, stat_word(cnt, 1'b1, n > D + 1));
            cyc();
            rd   = 1'b0;
            addr = '0;
            wait_idle("rnd_idle", 4000, 1'b1);
            run(5);
            decode("rnd", b, q, 1'b1);
            check("rnd_hold", 32'(holdbad - hb), 32'd0);
            check_stat("rnd_stat_end", stat_word(0, 1'b0, 1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
